// File: rtl/regfile_ckpt.sv
// regfile_ckpt: 2R/1W register file with a shadow checkpoint bank and NREG-cycle restore.
// Define REGFILE_WR_BYPASS_EN for same-cycle write-through on the read ports.
module regfile_ckpt #(
  parameter int WIDTH   = 16,
  parameter int NREG    = 8,
  parameter int AW      = $clog2(NREG),
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr0,
  output logic [WIDTH-1:0] rd_data0,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  input  logic             ckpt_save,
  input  logic             ckpt_restore,
  output logic             ckpt_valid,
  output logic             busy,
  output logic             restore_done
);

  localparam bit ZR = (ZERO_R0 != 0);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  typedef enum logic {
    S_IDLE,
    S_RESTORE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] live_q   [NREG];
  logic [WIDTH-1:0] live_d   [NREG];
  logic [WIDTH-1:0] shadow_q [NREG];
  logic [WIDTH-1:0] shadow_d [NREG];
  logic [AW-1:0]    idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             done_d;

  always_comb begin
    state_d  = state_q;
    live_d   = live_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wr_en && !(ZR && wr_addr == '0)) begin
          live_d[wr_addr] = wr_data;
        end
        // restore beats save; the save reads live_q so it sees pre-write data
        if (ckpt_restore && valid_q) begin
          state_d = S_RESTORE;
          idx_d   = '0;
        end else if (ckpt_save) begin
          shadow_d = live_q;
          valid_d  = 1'b1;
        end
      end
      S_RESTORE: begin
        if (!(ZR && idx_q == '0)) begin
          live_d[idx_q] = shadow_q[idx_q];
        end
        idx_d = idx_q + AW'(1);
        if (idx_q == LAST) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      live_q   <= live_d;
      shadow_q <= shadow_d;
    end
  end

  assign ckpt_valid   = valid_q;
  assign busy         = (state_q == S_RESTORE);
  assign restore_done = done_d;

  always_comb begin
    rd_data0 = live_q[rd_addr0];
`ifdef REGFILE_WR_BYPASS_EN
    if (wr_en && !busy && wr_addr == rd_addr0) begin
      rd_data0 = wr_data;
    end
`endif
    if (ZR && rd_addr0 == '0) begin
      rd_data0 = '0;
    end
  end

  always_comb begin
    rd_data1 = live_q[rd_addr1];
`ifdef REGFILE_WR_BYPASS_EN
    if (wr_en && !busy && wr_addr == rd_addr1) begin
      rd_data1 = wr_data;
    end
`endif
    if (ZR && rd_addr1 == '0) begin
      rd_data1 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_ckpt.sv
// tb_regfile_ckpt: directed scoreboard bench for regfile_ckpt.
// A second instance with ZERO_R0=1 shares all inputs.
module tb_regfile_ckpt;

`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr0;
  logic [2:0]  rd_addr1;
  logic        ckpt_save;
  logic        ckpt_restore;
  logic [15:0] rd_data0, rd_data1;
  logic        ckpt_valid, busy, restore_done;
  logic [15:0] z_d0, z_d1;
  logic        z_valid, z_busy, z_done;

  regfile_ckpt #(.WIDTH(16), .NREG(8), .ZERO_R0(0)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(rd_data0),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1),
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
    .ckpt_valid(ckpt_valid), .busy(busy),
    .restore_done(restore_done)
  );

  regfile_ckpt #(.WIDTH(16), .NREG(8), .ZERO_R0(1)) dut_z (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(z_d0),
    .rd_addr1(rd_addr1), .rd_data1(z_d1),
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
    .ckpt_valid(z_valid), .busy(z_busy),
    .restore_done(z_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        b;
    logic        v;
    logic        dn;
    bit          cz;
    logic [15:0] z0;
    logic [15:0] z1;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] byp(input logic [15:0] o, input logic [15:0] n);
    return BYP ? n : o;
  endfunction

  // monitor: one expectation per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (rd_data0 !== e.d0 || rd_data1 !== e.d1 || busy !== e.b ||
          ckpt_valid !== e.v || restore_done !== e.dn) begin
        bad++;
        $display("FAIL %s: got d0=%h d1=%h busy=%b valid=%b done=%b want d0=%h d1=%h busy=%b valid=%b done=%b",
                 e.nm, rd_data0, rd_data1, busy, ckpt_valid, restore_done,
                 e.d0, e.d1, e.b, e.v, e.dn);
      end
      if (e.cz) begin
        total++;
        if (z_d0 !== e.z0 || z_d1 !== e.z1 || z_busy !== e.b ||
            z_valid !== e.v || z_done !== e.dn) begin
          bad++;
          $display("FAIL %s_z: got d0=%h d1=%h busy=%b valid=%b done=%b want d0=%h d1=%h",
                   e.nm, z_d0, z_d1, z_busy, z_valid, z_done, e.z0, e.z1);
        end
      end
    end
  end

  task automatic put(input string nm, input logic [15:0] e0, input logic [15:0] e1,
                     input logic eb, input logic ev, input logic ed,
                     input bit cz, input logic [15:0] z0, input logic [15:0] z1);
    exp_t e;
    e.nm = nm; e.d0 = e0; e.d1 = e1;
    e.b = eb; e.v = ev; e.dn = ed;
    e.cz = cz; e.z0 = z0; e.z1 = z1;
    q.push_back(e);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    ckpt_save = 1'b0;
    ckpt_restore = 1'b0;
  endtask

  task automatic cyc(input string nm, input logic [15:0] e0, input logic [15:0] e1,
                     input logic eb, input logic ev, input logic ed);
    put(nm, e0, e1, eb, ev, ed, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr0 = '0; rd_addr1 = '0;
    ckpt_save = 1'b0; ckpt_restore = 1'b0;
    @(posedge clk);
    #1;
    put("reset", 16'h0, 16'h0, 0, 0, 0, 1'b1, 16'h0, 16'h0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_addr0 = 3'(i); rd_addr1 = 3'(7 - i);
      put("rd_all", 16'h0, 16'h0, 0, 0, 0, 1'b1, 16'h0, 16'h0);
    end

    rd_addr0 = 3; rd_addr1 = 3;
    wr(3, 16'hBEEF);
    cyc("wr_same", byp(16'h0, 16'hBEEF), byp(16'h0, 16'hBEEF), 0, 0, 0);
    cyc("wr_next", 16'hBEEF, 16'hBEEF, 0, 0, 0);

    rd_addr0 = 0; rd_addr1 = 0;
    for (int i = 1; i < 8; i++) begin
      wr(3'(i), 16'(i));
      cyc("fill", 16'h0, 16'h0, 0, 0, 0);
    end
    rd_addr0 = 2; rd_addr1 = 7;
    ckpt_save = 1'b1;
    cyc("save", 16'h2, 16'h7, 0, 0, 0);
    wr(2, 16'hFFFF);
    cyc("ovw", byp(16'h2, 16'hFFFF), 16'h7, 0, 1, 0);
    ckpt_restore = 1'b1;
    cyc("rs_go", 16'hFFFF, 16'h7, 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      rd_addr1 = 3'(k);
      cyc("rs1", (k <= 2) ? 16'hFFFF : 16'h2,
          (k == 2) ? 16'hFFFF : 16'(k), 1, 1, k == 7);
    end
    rd_addr0 = 2; rd_addr1 = 5;
    cyc("rs1_end", 16'h2, 16'h5, 0, 1, 0);

    rd_addr0 = 5; rd_addr1 = 6;
    wr(5, 16'h9999);
    cyc("pre_w5", byp(16'h5, 16'h9999), 16'h6, 0, 1, 0);
    ckpt_restore = 1'b1;
    wr(6, 16'h7777);
    cyc("rs_wr", 16'h9999, byp(16'h6, 16'h7777), 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      rd_addr1 = 3'(k);
      if (k == 1) begin
        wr(5, 16'h1234);
        ckpt_save = 1'b1;
        ckpt_restore = 1'b1;
      end
      cyc("rs2", (k <= 5) ? 16'h9999 : 16'h5,
          (k == 5) ? 16'h9999 : (k == 6) ? 16'h7777 : 16'(k),
          1, 1, k == 7);
    end
    rd_addr0 = 5; rd_addr1 = 6;
    cyc("rs2_end", 16'h5, 16'h6, 0, 1, 0);

    rd_addr0 = 0; rd_addr1 = 0;
    wr(0, 16'hAAAA);
    put("r0_wr", byp(16'h0, 16'hAAAA), byp(16'h0, 16'hAAAA), 0, 1, 0,
        1'b1, 16'h0, 16'h0);
    put("r0_rd", 16'hAAAA, 16'hAAAA, 0, 1, 0, 1'b1, 16'h0, 16'h0);

    rd_addr0 = 5; rd_addr1 = 0;
    ckpt_restore = 1'b1;
    cyc("rs3_go", 16'h5, 16'hAAAA, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc("rs3", 16'h5, (k == 0) ? 16'hAAAA : 16'h0, 1, 1, 0);
    end
    rst = 1'b0;
    put("rst_mid", 16'h0, 16'h0, 0, 0, 0, 1'b1, 16'h0, 16'h0);
    rst = 1'b1;
    put("rst_rel", 16'h0, 16'h0, 0, 0, 0, 1'b1, 16'h0, 16'h0);

    rd_addr0 = 4; rd_addr1 = 1;
    wr(4, 16'h0044);
    cyc("nv_wr", byp(16'h0, 16'h0044), 16'h0, 0, 0, 0);
    ckpt_restore = 1'b1;
    cyc("nv_rs", 16'h0044, 16'h0, 0, 0, 0);
    cyc("nv_chk", 16'h0044, 16'h0, 0, 0, 0);

    ckpt_save = 1'b1;
    cyc("sv2", 16'h0044, 16'h0, 0, 0, 0);
    wr(4, 16'h0055);
    cyc("w55", byp(16'h0044, 16'h0055), 16'h0, 0, 1, 0);
    ckpt_save = 1'b1;
    ckpt_restore = 1'b1;
    cyc("sv_rs", 16'h0055, 16'h0, 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      rd_addr1 = 3'(k);
      cyc("rs4", (k <= 4) ? 16'h0055 : 16'h0044,
          (k == 4) ? 16'h0055 : 16'h0, 1, 1, k == 7);
    end
    rd_addr1 = 4;
    cyc("rs4_end", 16'h0044, 16'h0044, 0, 1, 0);

    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
